// File: rtl/sobel_edge_3x3.sv
// Sobel 3x3 edge detector on a streaming RGB video input.
// Ports:
//   clk, rstn               pixel clock, asynchronous active-low reset
//   i_en                    1 = Sobel result, 0 = cur passed through unmodified
//   hsync, vsync, de, x, y  timing and coordinate of the current pixel
//   cur                     pixel (x,y) as {r,g,b}
//   line1, line2            pixels (x,y-2) and (x,y-1), one clk after x is presented
//   o_hsync..o_y            input timing/coordinates delayed by 5 clk
//   o_rgb                   result for window centre (o_x-1, o_y-1), or bypassed cur
module sobel_edge_3x3 #(
  parameter logic [11:0] H_ACT  = 12'd1280,
  parameter logic [11:0] V_ACT  = 12'd720,
  parameter logic [7:0]  THRESH = 8'd64,
  parameter logic        BINARY = 1'b1,
  localparam int unsigned XW = $clog2(H_ACT),
  localparam int unsigned YW = $clog2(V_ACT)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_en,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [23:0]   cur,
  input  logic [23:0]   line1,
  input  logic [23:0]   line2,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [23:0]   o_rgb
);

  // Y = (77R + 150G + 29B) >> 8; the weights sum to 256 so the sum fits 16 bits
  function automatic logic [7:0] to_gray(input logic [23:0] p);
    logic [15:0] acc;
    acc = 16'd77  * 16'(p[23:16])
        + 16'd150 * 16'(p[15:8])
        + 16'd29  * 16'(p[7:0]);
    return 8'(acc >> 8);
  endfunction

  // Stage 0: align cur and timing with line1/line2
  logic          s0_de, s0_hs, s0_vs, s0_en;
  logic [XW-1:0] s0_x;
  logic [YW-1:0] s0_y;
  logic [23:0]   s0_cur;

  // Stage 1: gray column
  logic          s1_de, s1_hs, s1_vs, s1_en;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic [23:0]   s1_cur;
  logic [7:0]    g_top, g_mid, g_bot;

  // Stage 2: window, p<row><col>; row 0 = line1, col 2 = newest
  logic          s2_de, s2_hs, s2_vs, s2_en, s2_full;
  logic [XW-1:0] s2_x;
  logic [YW-1:0] s2_y;
  logic [23:0]   s2_cur;
  logic [7:0]    p00, p01, p02, p10, p11, p12, p20, p21, p22;

  // Stage 3: gradients
  logic               s3_de, s3_hs, s3_vs, s3_en, s3_full;
  logic [XW-1:0]      s3_x;
  logic [YW-1:0]      s3_y;
  logic [23:0]        s3_cur;
  logic signed [10:0] gx, gy;

  // Combinational gradient and magnitude terms
  logic [9:0]         gx_pos_c, gx_neg_c, gy_pos_c, gy_neg_c;
  logic signed [10:0] gx_c, gy_c;
  logic [10:0]        ax_c, ay_c;
  logic [11:0]        mag_c;
  logic [7:0]         sat_c;
  logic [23:0]        rgb_c;

  // Stage 0 register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_de  <= 1'b0;
      s0_hs  <= 1'b0;
      s0_vs  <= 1'b0;
      s0_en  <= 1'b0;
      s0_x   <= '0;
      s0_y   <= '0;
      s0_cur <= '0;
    end else begin
      s0_de  <= de;
      s0_hs  <= hsync;
      s0_vs  <= vsync;
      s0_en  <= i_en;
      s0_x   <= x;
      s0_y   <= y;
      s0_cur <= cur;
    end
  end

  // Stage 1 register: gray conversion of the aligned column
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_de  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_en  <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_cur <= '0;
      g_top  <= '0;
      g_mid  <= '0;
      g_bot  <= '0;
    end else begin
      s1_de  <= s0_de;
      s1_hs  <= s0_hs;
      s1_vs  <= s0_vs;
      s1_en  <= s0_en;
      s1_x   <= s0_x;
      s1_y   <= s0_y;
      s1_cur <= s0_cur;
      g_top  <= to_gray(line1);
      g_mid  <= to_gray(line2);
      g_bot  <= to_gray(s0_cur);
    end
  end

  // Stage 2 register: window shift on active pixels only.
  // The clear fires on a de rise at the start of a line; a de gap
  // inside a line keeps the window so results are gap-independent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_de   <= 1'b0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
      s2_en   <= 1'b0;
      s2_full <= 1'b0;
      s2_x    <= '0;
      s2_y    <= '0;
      s2_cur  <= '0;
      p00 <= '0; p01 <= '0; p02 <= '0;
      p10 <= '0; p11 <= '0; p12 <= '0;
      p20 <= '0; p21 <= '0; p22 <= '0;
    end else begin
      s2_de   <= s1_de;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_en   <= s1_en;
      s2_full <= (s1_x >= XW'(2)) && (s1_y >= YW'(2));
      s2_x    <= s1_x;
      s2_y    <= s1_y;
      s2_cur  <= s1_cur;
      if (s1_de) begin
        if (!s2_de && (s1_x == '0)) begin
          p00 <= '0; p01 <= '0;
          p10 <= '0; p11 <= '0;
          p20 <= '0; p21 <= '0;
        end else begin
          p00 <= p01; p01 <= p02;
          p10 <= p11; p11 <= p12;
          p20 <= p21; p21 <= p22;
        end
        p02 <= g_top;
        p12 <= g_mid;
        p22 <= g_bot;
      end
    end
  end

  // Gradient kernels; each half-sum is at most 4*255 = 1020
  always_comb begin
    gx_pos_c = 10'(p02) + 10'({p12, 1'b0}) + 10'(p22);
    gx_neg_c = 10'(p00) + 10'({p10, 1'b0}) + 10'(p20);
    gy_pos_c = 10'(p20) + 10'({p21, 1'b0}) + 10'(p22);
    gy_neg_c = 10'(p00) + 10'({p01, 1'b0}) + 10'(p02);
    gx_c     = $signed({1'b0, gx_pos_c}) - $signed({1'b0, gx_neg_c});
    gy_c     = $signed({1'b0, gy_pos_c}) - $signed({1'b0, gy_neg_c});
  end

  // Stage 3 register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_de   <= 1'b0;
      s3_hs   <= 1'b0;
      s3_vs   <= 1'b0;
      s3_en   <= 1'b0;
      s3_full <= 1'b0;
      s3_x    <= '0;
      s3_y    <= '0;
      s3_cur  <= '0;
      gx      <= '0;
      gy      <= '0;
    end else begin
      s3_de   <= s2_de;
      s3_hs   <= s2_hs;
      s3_vs   <= s2_vs;
      s3_en   <= s2_en;
      s3_full <= s2_full;
      s3_x    <= s2_x;
      s3_y    <= s2_y;
      s3_cur  <= s2_cur;
      gx      <= gx_c;
      gy      <= gy_c;
    end
  end

  // Magnitude, saturation and output selection
  always_comb begin
    ax_c  = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    ay_c  = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    mag_c = 12'(ax_c) + 12'(ay_c);
    sat_c = (mag_c > 12'd255) ? 8'hFF : mag_c[7:0];
    rgb_c = '0;
    if (s3_de) begin
      if (!s3_en) begin
        rgb_c = s3_cur;
      end else if (s3_full) begin
        if (BINARY) begin
          rgb_c = (sat_c >= THRESH) ? 24'hFFFFFF : 24'h000000;
        end else begin
          rgb_c = {sat_c, sat_c, sat_c};
        end
      end
    end
  end

  // Stage 4: output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_de    <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_rgb   <= '0;
    end else begin
      o_hsync <= s3_hs;
      o_vsync <= s3_vs;
      o_de    <= s3_de;
      o_x     <= s3_x;
      o_y     <= s3_y;
      o_rgb   <= rgb_c;
    end
  end

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Scoreboard bench for sobel_edge_3x3: a binary-mode and a magnitude-mode
// instance share one directed stimulus stream; the driver queues expected
// pixels and a negedge monitor checks them against the outputs.
module tb_sobel_edge_3x3;
  localparam logic [11:0] H_ACT = 12'd128;
  localparam logic [11:0] V_ACT = 12'd8;
  localparam int unsigned XW = $clog2(H_ACT);
  localparam int unsigned YW = $clog2(V_ACT);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_en = 1'b0, hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic [23:0]   cur = '0, line1 = '0, line2 = '0;

  logic          b_hs, b_vs, b_de, m_hs, m_vs, m_de;
  logic [XW-1:0] b_x, m_x;
  logic [YW-1:0] b_y, m_y;
  logic [23:0]   b_rgb, m_rgb;

  sobel_edge_3x3 #(.H_ACT(H_ACT), .V_ACT(V_ACT), .THRESH(8'd64), .BINARY(1'b1)) dut_bin (
    .clk(clk), .rstn(rstn), .i_en(i_en), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .cur(cur), .line1(line1), .line2(line2),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_x(b_x), .o_y(b_y), .o_rgb(b_rgb));

  sobel_edge_3x3 #(.H_ACT(H_ACT), .V_ACT(V_ACT), .THRESH(8'd64), .BINARY(1'b0)) dut_mag (
    .clk(clk), .rstn(rstn), .i_en(i_en), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .cur(cur), .line1(line1), .line2(line2),
    .o_hsync(m_hs), .o_vsync(m_vs), .o_de(m_de), .o_x(m_x), .o_y(m_y), .o_rgb(m_rgb));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ex;
    int          ey;
    logic [23:0] eb;
    logic [23:0] em;
  } exp_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } tim_t;

  exp_t        q[$];
  tim_t        hist[64];
  int          tests = 0;
  int          fails = 0;
  bit          mon_on = 1'b0;
  logic [23:0] pend_l1 = '0, pend_l2 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // One clock of stimulus; line1/line2 lag the pixel they belong to by one clk
  task automatic drive(input logic d, input logic h, input logic v, input logic e,
                       input int px, input int py, input logic [23:0] c,
                       input logic [23:0] l1n, input logic [23:0] l2n,
                       input bit rec, input logic [23:0] eb, input logic [23:0] em);
    exp_t it;
    @(posedge clk);
    #1;
    line1   = pend_l1;
    line2   = pend_l2;
    pend_l1 = l1n;
    pend_l2 = l2n;
    de = d; hsync = h; vsync = v; i_en = e;
    x  = XW'(px);
    y  = YW'(py);
    cur = c;
    hist[cyc % 64] = '{de: d & rec, hs: h & rec, vs: v & rec};
    if (d && rec) begin
      it.ex = px; it.ey = py; it.eb = eb; it.em = em;
      q.push_back(it);
    end
  endtask

  task automatic idle(input int n, input logic h, input logic v);
    for (int i = 0; i < n; i++) drive(1'b0, h, v, 1'b1, 0, 0, 24'h0, 24'h0, 24'h0, 1'b1, 24'h0, 24'h0);
  endtask

  function automatic logic [23:0] pix(input bit horiz, input int px, input int py,
                                      input int e, input logic [23:0] lc, input logic [23:0] rc);
    int k;
    k = horiz ? py : px;
    return (k < e) ? lc : rc;
  endfunction

  // Step image: lc before column/row e, rc from e on. Windows straddling the
  // step (index e and e+1) give the hand-computed vb/vm, all others give 0.
  task automatic run_frame(input bit horiz, input int e, input int gap_at,
                           input logic [23:0] lc, input logic [23:0] rc,
                           input logic [23:0] vb, input logic [23:0] vm);
    bit hit;
    idle(2, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);
    for (int py = 0; py < 5; py++) begin
      idle(2, 1'b1, 1'b0);
      idle(2, 1'b0, 1'b0);
      for (int px = 0; px < 16; px++) begin
        if (px == gap_at) idle(3, 1'b0, 1'b0);
        hit = horiz ? (py == e || py == e + 1) : (px == e || px == e + 1);
        if (px < 2 || py < 2) hit = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, px, py, pix(horiz, px, py, e, lc, rc),
              pix(horiz, px, py - 2, e, lc, rc), pix(horiz, px, py - 1, e, lc, rc),
              1'b1, hit ? vb : 24'h0, hit ? vm : 24'h0);
      end
    end
  endtask

  // Flat field with i_en=1 below x=100, random bypass pixels from x=100 on
  task automatic run_bypass();
    logic [23:0] r;
    for (int py = 0; py < 3; py++) begin
      idle(2, 1'b1, 1'b0);
      idle(2, 1'b0, 1'b0);
      for (int px = 0; px < 128; px++) begin
        if (px < 100) begin
          drive(1'b1, 1'b0, 1'b0, 1'b1, px, py, 24'h808080, 24'h808080, 24'h808080,
                1'b1, 24'h0, 24'h0);
        end else begin
          r = 24'($urandom);
          drive(1'b1, 1'b0, 1'b0, 1'b0, px, py, r, 24'h0, 24'h0, 1'b1, r, r);
        end
      end
    end
  endtask

  // Monitor: timing against the driven history, data against the queue
  always @(negedge clk) begin : monitor
    tim_t h;
    exp_t it;
    if (mon_on && cyc >= 5) begin
      h = hist[(cyc - 5) % 64];
      check("o_de_latency", 32'(b_de), 32'(h.de));
      check("o_hsync", 32'(b_hs), 32'(h.hs));
      check("o_vsync", 32'(b_vs), 32'(h.vs));
      check("mag_o_de", 32'(m_de), 32'(h.de));
      check("mag_o_hsync", 32'(m_hs), 32'(h.hs));
      check("mag_o_vsync", 32'(m_vs), 32'(h.vs));
      if (b_de) begin
        if (q.size() == 0) begin
          check("queue_underflow", 32'(q.size()), 32'd1);
        end else begin
          it = q.pop_front();
          check("o_x", 32'(b_x), 32'(it.ex));
          check("o_y", 32'(b_y), 32'(it.ey));
          check("o_rgb_bin", 32'(b_rgb), 32'(it.eb));
          check("mag_o_x", 32'(m_x), 32'(it.ex));
          check("mag_o_y", 32'(m_y), 32'(it.ey));
          check("o_rgb_mag", 32'(m_rgb), 32'(it.em));
        end
      end else begin
        check("o_rgb_idle_bin", 32'(b_rgb), 32'd0);
        check("o_rgb_idle_mag", 32'(m_rgb), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) hist[i] = '0;

    // Reset: fill the pipeline, pulse rstn low mid-cycle, outputs clear at once
    idle(3, 1'b0, 1'b0);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, 1'b0, 1'b0, i + 3, 2, 24'h123456, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0);
    check("pre_reset_o_de", 32'(b_de), 32'd1);
    check("pre_reset_o_rgb", 32'(b_rgb), 32'h123456);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_o_de", 32'(b_de), 32'd0);
    check("rst_o_hsync", 32'(b_hs), 32'd0);
    check("rst_o_vsync", 32'(b_vs), 32'd0);
    check("rst_o_x", 32'(b_x), 32'd0);
    check("rst_o_y", 32'(b_y), 32'd0);
    check("rst_o_rgb", 32'(b_rgb), 32'd0);
    check("rst_mag_o_rgb", 32'(m_rgb), 32'd0);
    idle(3, 1'b0, 1'b0);
    rstn = 1'b1;
    mon_on = 1'b1;
    idle(2, 1'b0, 1'b0);

    // Flat grey field: no gradient anywhere
    run_frame(1'b0, 8, -1, 24'h808080, 24'h808080, 24'h000000, 24'h000000);
    // Black/white vertical edge at x=8: |Gx|=1020 saturates
    run_frame(1'b0, 8, -1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    // Same edge at column 1: only x=2 (and y>=2) survives the border mask
    run_frame(1'b0, 1, -1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    // Edge with a 3-clk de gap just before the edge column
    run_frame(1'b0, 8, 8, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    // Gray 16 -> 32: mag 64 equals THRESH
    run_frame(1'b0, 8, -1, 24'h101010, 24'h202020, 24'hFFFFFF, 24'h404040);
    // Gray 16 -> 31: mag 60 below THRESH
    run_frame(1'b0, 8, -1, 24'h101010, 24'h1F1F1F, 24'h000000, 24'h3C3C3C);
    // Falling edge 32 -> 16: negative Gx, mag 64
    run_frame(1'b0, 8, -1, 24'h202020, 24'h101010, 24'hFFFFFF, 24'h404040);
    // Mixed colour 0x402010 -> gray 39, mag 156
    run_frame(1'b0, 8, -1, 24'h000000, 24'h402010, 24'hFFFFFF, 24'h9C9C9C);
    // Horizontal edge at row 3 exercises Gy: mag 64
    run_frame(1'b1, 3, -1, 24'h000000, 24'h101010, 24'hFFFFFF, 24'h404040);
    // Horizontal black/white edge saturates Gy
    run_frame(1'b1, 3, 5, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    // Bypass switch at x=100
    run_bypass();

    idle(10, 1'b0, 1'b0);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
